// File: rtl/qerv_rf_ram_ctrl.sv
// ----------------------------------------------------------------------------
// qerv_rf_ram_ctrl
//
// Register-file storage controller that sits behind qerv_rf_ram_if. It holds
// the 1R1W storage array and provides registered reads with one-cycle latency.
// When a read and a write hit the same address in the same cycle, the read
// returns the old contents.
//
// After every reset a hardware sweep writes zero to every entry. o_init_done
// goes high once that sweep has finished, so the core can be held until then.
//
// Optional feature macro: QERV_RF_RAM_PARITY_EN
//   - Defined:   each entry also stores one parity bit, and every read checks
//                that bit.
//   - Undefined: no parity is stored, and the error outputs are tied to 0.
//
// Ports
//   i_clk         clock
//   i_rst         synchronous, active-high reset
//   i_waddr       write word address            (aw bits)
//   i_wdata       write data                    (width bits)
//   i_wen         write enable
//   i_raddr       read word address             (aw bits)
//   i_ren         read enable
//   o_rdata       registered read data          (width bits)
//   o_init_done   high once the clear sweep has completed
//   o_parity_err  one-cycle pulse, aligned with o_rdata, on a parity failure
//   o_err_sticky  set on the first parity error, cleared only by reset
//   o_err_addr    address of the first parity error since reset (aw bits)
// ----------------------------------------------------------------------------
module qerv_rf_ram_ctrl #(
    parameter int width    = 8,
    parameter int csr_regs = 4,
    parameter int raw      = $clog2(32 + csr_regs),
    parameter int l2w      = $clog2(width),
    parameter int aw       = 5 + raw - l2w,
    parameter int depth    = 2 ** aw
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata,
    output logic             o_init_done,
    output logic             o_parity_err,
    output logic             o_err_sticky,
    output logic [aw-1:0]    o_err_addr
);

`ifdef QERV_RF_RAM_PARITY_EN
    localparam int sw = width + 1;   // parity bit sits at index [width]
`else
    localparam int sw = width;
`endif

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state, state_next;

    // The sweep counter has one extra bit. The top bit sets once the last
    // entry has been written. The machine then spends one more cycle in CLEAR
    // before it enters RUN.
    logic [aw:0]     scnt, scnt_next;

    logic            mem_we;
    logic [aw-1:0]   mem_addr;
    logic [sw-1:0]   mem_wword;
    logic            rd_en;

    logic [sw-1:0]   mem [depth];

    // Next-state logic and write-port mux.
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the block can leave a latch behind.
    always_comb begin
        state_next = state;
        scnt_next  = scnt;
        mem_we     = 1'b0;
        mem_addr   = i_waddr;
        mem_wword  = '0;
        rd_en      = 1'b0;

        unique case (state)
            CLEAR: begin
                if (!scnt[aw]) begin
                    mem_we    = 1'b1;
                    mem_addr  = scnt[aw-1:0];
                    scnt_next = scnt + 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                mem_we   = i_wen;
                mem_addr = i_waddr;
`ifdef QERV_RF_RAM_PARITY_EN
                mem_wword = {^i_wdata, i_wdata};
`else
                mem_wword = i_wdata;
`endif
                rd_en    = i_ren;
            end
            default: state_next = CLEAR;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the values from before the edge, and that is what gives
    // the read-before-write collision behaviour below.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= CLEAR;
            scnt        <= '0;
            o_init_done <= 1'b0;
        end else begin
            state       <= state_next;
            scnt        <= scnt_next;
            o_init_done <= (state_next == RUN);
        end
    end

    // Storage array.
    // NOTE: the array has no reset; the post-reset sweep provides its initial
    // contents. Writes are blocked while i_rst is high.
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_rst) begin
            mem[mem_addr] <= mem_wword;
        end
    end

    // Registered read port. It holds its value when no read is issued, and
    // also throughout CLEAR.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rdata <= '0;
        end else if (rd_en) begin
            o_rdata <= mem[i_raddr][width-1:0];
        end
    end

`ifdef QERV_RF_RAM_PARITY_EN
    // The check is evaluated on the word as it is read. The result is
    // registered together with the data, so the error pulse lines up with
    // the o_rdata update.
    logic rd_bad;
    assign rd_bad = rd_en && (mem[i_raddr][width] != ^mem[i_raddr][width-1:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_parity_err <= 1'b0;
            o_err_sticky <= 1'b0;
            o_err_addr   <= '0;
        end else begin
            o_parity_err <= rd_bad;
            if (rd_bad && !o_err_sticky) begin
                o_err_sticky <= 1'b1;
                o_err_addr   <= i_raddr;
            end
        end
    end
`else
    assign o_parity_err = 1'b0;
    assign o_err_sticky = 1'b0;
    assign o_err_addr   = '0;
`endif

endmodule

// File: tb/tb_qerv_rf_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_qerv_rf_ram_ctrl
//
// Self-checking bench for qerv_rf_ram_ctrl with width=8 and csr_regs=4, which
// gives depth=256. A behavioural model tracks the following:
//   - which edges since reset release fall inside the sweep;
//   - the array contents;
//   - the read register;
//   - which entries have been corrupted behind the controller's back.
// Every cycle, all outputs are compared with the model one time unit after
// the rising edge.
// ----------------------------------------------------------------------------
module tb_qerv_rf_ram_ctrl;

    localparam int WIDTH = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic             clk;
    logic             rst;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             wen;
    logic [AW-1:0]    raddr;
    logic             ren;
    logic [WIDTH-1:0] rdata;
    logic             init_done;
    logic             parity_err;
    logic             err_sticky;
    logic [AW-1:0]    err_addr;

    qerv_rf_ram_ctrl #(
        .width    (WIDTH),
        .csr_regs (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_waddr      (waddr),
        .i_wdata      (wdata),
        .i_wen        (wen),
        .i_raddr      (raddr),
        .i_ren        (ren),
        .o_rdata      (rdata),
        .o_init_done  (init_done),
        .o_parity_err (parity_err),
        .o_err_sticky (err_sticky),
        .o_err_addr   (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard counters.
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_bad [DEPTH];
    logic [WIDTH-1:0] m_rdata;
    bit               m_done;
    int               m_edges;
    bit               m_perr;
    bit               m_sticky;
    logic [AW-1:0]    m_eaddr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // A reset puts the model back to its reset state. The sweep will zero
    // every entry, and no user access is accepted until the sweep completes,
    // so the model array can be zeroed right away.
    task automatic model_reset();
        foreach (m_mem[i]) begin
            m_mem[i] = '0;
            m_bad[i] = 1'b0;
        end
        m_rdata  = '0;
        m_done   = 1'b0;
        m_edges  = 0;
        m_perr   = 1'b0;
        m_sticky = 1'b0;
        m_eaddr  = '0;
    endtask

    // Holds reset over two edges and releases it on a falling edge.
    // The task is entered and left on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        wen = 1'b0;
        ren = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Applies one cycle of stimulus, advances the model by one edge, and
    // compares every output. The task is entered and left on a falling edge.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                        input logic re, input logic [AW-1:0] ra);
        wen   = we;
        waddr = wa;
        wdata = wd;
        ren   = re;
        raddr = ra;
        @(posedge clk);
        m_perr = 1'b0;
        if (m_done) begin
            if (re) begin
                m_rdata = m_mem[ra];
                m_perr  = m_bad[ra];
                if (m_perr && !m_sticky) begin
                    m_sticky = 1'b1;
                    m_eaddr  = ra;
                end
            end
            if (we) begin
                m_mem[wa] = wd;
                m_bad[wa] = 1'b0;
            end
        end
        m_edges++;
        if (m_edges >= DEPTH + 1) m_done = 1'b1;
        #1;
        check("rdata",      rdata,      m_rdata);
        check("init_done",  init_done,  m_done);
        check("parity_err", parity_err, m_perr);
        check("err_sticky", err_sticky, m_sticky);
        check("err_addr",   err_addr,   m_eaddr);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0);
    endtask

    // Random traffic. Addresses are biased toward a small window so that
    // reads often hit earlier writes, and some cycles are forced collisions.
    task automatic random_ops(input int n);
        logic [AW-1:0] wa, ra;
        for (int i = 0; i < n; i++) begin
            wa = ($urandom % 3 == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            ra = ($urandom % 3 == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            if ($urandom % 4 == 0) ra = wa;
            step(1'($urandom), wa, WIDTH'($urandom), 1'($urandom), ra);
        end
    endtask

    int n_sweep;

    initial begin
        rst   = 1'b1;
        wen   = 1'b0;
        ren   = 1'b0;
        waddr = '0;
        wdata = '0;
        raddr = '0;
        model_reset();
        @(negedge clk);
        do_reset();
        check("reset_rdata", rdata, 0);
        check("reset_init_done", init_done, 0);

        // Sweep with a write attempt on sweep cycle 10 (it must be ignored),
        // then read every address.
        for (int i = 1; i <= DEPTH + 1; i++) begin
            if (i == 10) step(1'b1, 8'h05, 8'hA5, 1'b0, '0);
            else         idle();
        end
        for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, 1'b1, AW'(a));
        step(1'b0, '0, '0, 1'b1, 8'h05);
        check("clear_drop_write", rdata, 8'h00);

        // Basic write, read, and hold.
        step(1'b1, 8'h12, 8'h3C, 1'b0, '0);
        step(1'b0, '0, '0, 1'b1, 8'h12);
        check("basic_read", rdata, 8'h3C);
        idle();
        check("basic_hold", rdata, 8'h3C);

        // Read/write collision returns the old contents.
        step(1'b1, 8'h20, 8'h11, 1'b0, '0);
        step(1'b1, 8'h20, 8'h99, 1'b1, 8'h20);
        check("collision_old", rdata, 8'h11);
        step(1'b0, '0, '0, 1'b1, 8'h20);
        check("collision_new", rdata, 8'h99);

`ifdef QERV_RF_RAM_PARITY_EN
        // Corrupt the stored bit 0 behind the controller's back.
        step(1'b1, 8'h40, 8'h0F, 1'b0, '0);
        dut.mem[8'h40][0] = ~dut.mem[8'h40][0];
        m_mem[8'h40] = m_mem[8'h40] ^ 8'h01;
        m_bad[8'h40] = 1'b1;
        step(1'b0, '0, '0, 1'b1, 8'h40);
        check("perr_pulse", parity_err, 1);
        check("perr_addr", err_addr, 8'h40);
        idle();
        check("perr_single_cycle", parity_err, 0);
        step(1'b1, 8'h41, 8'h33, 1'b0, '0);
        dut.mem[8'h41][3] = ~dut.mem[8'h41][3];
        m_mem[8'h41] = m_mem[8'h41] ^ 8'h08;
        m_bad[8'h41] = 1'b1;
        step(1'b0, '0, '0, 1'b1, 8'h41);
        check("perr_second_addr_kept", err_addr, 8'h40);
        check("perr_sticky", err_sticky, 1);
`endif

        random_ops(1500);

        // Reset in the middle of operation, then random traffic during the
        // sweep (ignored) and after it.
        do_reset();
        random_ops(DEPTH + 1);
        random_ops(800);

        // Reset at sweep cycle 100. The full sweep must restart.
        do_reset();
        repeat (100) idle();
        do_reset();
        n_sweep = 0;
        for (int i = 1; i <= DEPTH + 20; i++) begin
            idle();
            if (init_done === 1'b1) begin
                n_sweep = i;
                break;
            end
        end
        check("sweep_len_after_midreset", n_sweep, DEPTH + 1);
        for (int a = 0; a < 32; a++) step(1'b0, '0, '0, 1'b1, AW'($urandom));
        random_ops(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qerv_rf_ram_ctrl.md
# qerv_rf_ram_ctrl

Register-file storage controller directly downstream of `qerv_rf_ram_if`, taking its RAM-side port (`o_waddr`/`o_wdata`/`o_wen`/`o_raddr`/`o_ren`) and returning `i_rdata`. It holds the 1R1W storage array and gives registered reads with one-cycle latency and read-before-write collision semantics. After every reset it runs a hardware clear sweep that zeroes all GPR and CSR entries, and reports completion so the core can be held until then. Optional per-word parity detects storage corruption.

## Interface
Parameters:
- `width` = 8: data word width; must equal the `width` of the upstream interface.
- `csr_regs` = 4: CSR registers stored after the 32 GPRs.
- `raw` = $clog2(32+csr_regs): register address width. Derived; do not override.
- `l2w` = $clog2(width): derived.
- `aw` = 5+raw-l2w: word address width. Derived.
- `depth` = 2**aw: number of array entries. Derived.

Ports:
- `i_clk` in, 1: clock.
- `i_rst` in, 1: synchronous, active-high reset.
- `i_waddr` in, aw: write word address.
- `i_wdata` in, width: write data.
- `i_wen` in, 1: write enable.
- `i_raddr` in, aw: read word address.
- `i_ren` in, 1: read enable.
- `o_rdata` out, width: registered read data.
- `o_init_done` out, 1: high once the clear sweep has completed.
- `o_parity_err` out, 1: one-cycle pulse, aligned with `o_rdata`, when the word just read fails parity.
- `o_err_sticky` out, 1: sets on the first parity error and clears only on reset.
- `o_err_addr` out, aw: address of the first parity error since reset.

## Operation
- Storage is an array of `depth` entries. Each entry is `width` bits, plus 1 parity bit when parity is enabled. The array itself has no reset.
- The state machine has two states, CLEAR and RUN.
- Reset state is CLEAR, with sweep counter `scnt` = 0.
- **CLEAR:**
  - Each cycle, write all-zero data (and parity 0) to entry `scnt`, then increment `scnt`.
  - When `scnt` == `depth`-1 is written, move to RUN on the next edge.
  - `i_wen` and `i_ren` are ignored in CLEAR. User writes are dropped and `o_rdata` is held at 0.
- **RUN:**
  - When `i_wen`=1, write `i_wdata` to `i_waddr`, and store parity `^i_wdata`.
  - When `i_ren`=1, `o_rdata` takes `mem[i_raddr]` at the next edge.
  - When `i_ren`=0, `o_rdata` holds its value.
- **Read/write collision** (`i_ren` and `i_wen` in the same cycle, equal addresses): `o_rdata` returns the OLD contents (read-before-write). The new data is visible to reads issued from the following cycle on.
- **Parity check:**
  - On each RUN read, register the stored parity bit with the data.
  - The cycle `o_rdata` updates, `o_parity_err` = (stored parity != `^o_rdata`).
  - The first error since reset latches `o_err_addr` (the read address, pipelined) and sets `o_err_sticky`. Later errors do not change `o_err_addr`.
- **Reset mid-sweep or mid-operation:** the machine returns to CLEAR with `scnt`=0 and the sweep restarts from entry 0. No partial state is preserved.
- **Address range:** addresses ≥ 36×32/`width` are legal and are swept like every other entry. No range check is made.

## Timing
- **Reset values:**
  - `o_rdata` = 0
  - `o_init_done` = 0
  - `o_parity_err` = 0
  - `o_err_sticky` = 0
  - `o_err_addr` = 0
  - `scnt` = 0
- **Sweep length:** `depth` cycles. `o_init_done` rises on the edge after the last clear write, i.e. `depth`+1 edges after `i_rst` deasserts.
- **Read latency:** 1 cycle, with address and enable sampled on the same edge. Back-to-back reads are sustained every cycle.
- **Write:** takes effect at the edge where `i_wen` is sampled.
- `o_parity_err` is a single-cycle pulse per failing read, coincident with the `o_rdata` update.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- **Macro:** `QERV_RF_RAM_PARITY_EN`.
- **Defined:** the parity bit is stored per entry and checked as described above.
- **Undefined:**
  - The array is `width` bits wide with no parity.
  - `o_parity_err` and `o_err_sticky` are tied to 0, and `o_err_addr` is tied to 0.
  - All other behaviour and timing are identical.

## Test plan
- **Reset then sweep** (`width`=8, `csr_regs`=4, `depth`=256): release `i_rst`; `o_init_done`=0 for 256 cycles, then 1. A read of every address returns 0x00.
- **Write ignored during CLEAR:** at sweep cycle 10, pulse `i_wen` with address 0x05, data 0xA5. After init, a read of 0x05 returns 0x00.
- **Basic R/W in RUN:** write 0x3C to 0x12, then `i_ren` to 0x12 on the next cycle. `o_rdata`=0x3C one cycle later. With `i_ren`=0 afterwards, `o_rdata` stays 0x3C.
- **Collision:** 0x20 holds 0x11. Write 0x99 to 0x20 and read 0x20 in the same cycle: `o_rdata`=0x11. The next read returns 0x99.
- **Reset mid-sweep:** assert `i_rst` at sweep cycle 100, release it; `o_init_done` rises after a full 256 further cycles.
- **Parity (macro defined):** write 0x0F to 0x40, force-flip stored bit 0 through a hierarchical reference, read 0x40. The result is `o_parity_err` pulsed for 1 cycle, `o_err_sticky`=1, `o_err_addr`=0x40. A second error at 0x41 leaves `o_err_addr` at 0x40.
